// File: rtl/byte_lane_data_mem_if.sv
// Request/response bundle for the MEM-stage byte-lane data memory.
// The master drives the i_* requests; the memory drives the o_* results and o_ready.
interface byte_lane_data_mem_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4,
   parameter int ADDR_WIDTH = 12
);
   localparam int WORD_WIDTH = DATA_WIDTH * LANES;

   logic                  i_clear;
   logic                  i_req;
   logic                  i_we;
   logic [1:0]            i_size;
   logic                  i_unsigned;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic [WORD_WIDTH-1:0] i_data;
   logic [WORD_WIDTH-1:0] o_data;
   logic                  o_rvalid;
   logic                  o_err;
   logic                  o_ready;

   modport master (
      output i_clear, i_req, i_we, i_size, i_unsigned, i_addr, i_data,
      input  o_data, o_rvalid, o_err, o_ready
   );

   modport slave (
      input  i_clear, i_req, i_we, i_size, i_unsigned, i_addr, i_data,
      output o_data, o_rvalid, o_err, o_ready
   );
endinterface

// File: rtl/byte_lane_data_mem.sv
// Big-endian byte-addressed data memory with sized/extended loads, alignment errors,
// a registered read port and a one-word-per-cycle clear sweep gating o_ready.
module byte_lane_data_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4,
   parameter int ADDR_WIDTH = 12
) (
   input logic                  i_clk,
   input logic                  i_reset,
   byte_lane_data_mem_if.slave  bus
);
   localparam int WORD_WIDTH = DATA_WIDTH * LANES;
   localparam int LANE_BITS  = $clog2(LANES);
   localparam int WORDS      = (2 ** ADDR_WIDTH) / LANES;
   localparam int CNT_W      = (ADDR_WIDTH > LANE_BITS) ? ADDR_WIDTH - LANE_BITS : 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t                state, state_next;
   logic [CNT_W-1:0]      count, count_next;
   logic [WORD_WIDTH-1:0] mem [WORDS];

   logic [CNT_W-1:0]      word_idx;
   logic [LANE_BITS-1:0]  offset;
   logic                  legal, store_go, load_go, err_go;
   logic [LANES-1:0]      wr_mask;
   logic [WORD_WIDTH-1:0] wr_data, rd_word, load_val;
   logic [DATA_WIDTH-1:0] rd_bytes [LANES];
   logic [DATA_WIDTH-1:0] byte_val;
   logic [2*DATA_WIDTH-1:0] half_val;

   assign offset = bus.i_addr[LANE_BITS-1:0];

   generate
      if (ADDR_WIDTH > LANE_BITS) begin : g_word_idx
         assign word_idx = bus.i_addr[ADDR_WIDTH-1:LANE_BITS];
      end else begin : g_single_word
         assign word_idx = '0;
      end
   endgenerate

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= CLEAR;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   always_comb begin
      state_next = state;
      count_next = count;
      case (state)
         CLEAR: begin
            if (bus.i_clear) begin
               count_next = '0;
            end else if (count == LAST_WORD) begin
               state_next = READY;
               count_next = '0;
            end else begin
               count_next = count + CNT_W'(1);
            end
         end
         READY: begin
            if (bus.i_clear) begin
               state_next = CLEAR;
               count_next = '0;
            end
         end
         default: state_next = CLEAR;
      endcase
   end

   // Lane 0 holds the highest address of a word, so byte offset k lives in lane LANES-1-k.
   always_comb begin
      bus.o_ready = (state == READY);
      case (bus.i_size)
         2'b00:   legal = 1'b1;
         2'b01:   legal = ~offset[0];
         2'b10:   legal = (offset == '0);
         default: legal = 1'b0;
      endcase
      store_go = bus.o_ready & bus.i_req & ~bus.i_clear & legal & bus.i_we;
      load_go  = bus.o_ready & bus.i_req & ~bus.i_clear & legal & ~bus.i_we;
      err_go   = bus.o_ready & bus.i_req & ~bus.i_clear & ~legal;

      wr_mask = '0;
      for (int l = 0; l < LANES; l++) begin
         case (bus.i_size)
            2'b00:   wr_mask[l] = (LANE_BITS'(LANES - 1 - l) == offset);
            2'b01:   wr_mask[l] = ((LANE_BITS'(LANES - 1 - l) >> 1) == (offset >> 1));
            default: wr_mask[l] = 1'b1;
         endcase
      end
      case (bus.i_size)
         2'b00:   wr_data = {LANES{bus.i_data[DATA_WIDTH-1:0]}};
         2'b01:   wr_data = {(LANES / 2){bus.i_data[2*DATA_WIDTH-1:0]}};
         default: wr_data = bus.i_data;
      endcase

      rd_word = mem[word_idx];
      for (int k = 0; k < LANES; k++) begin
         rd_bytes[k] = rd_word[(LANES-1-k)*DATA_WIDTH +: DATA_WIDTH];
      end
      byte_val = rd_bytes[offset];
      half_val = {rd_bytes[offset], rd_bytes[offset | LANE_BITS'(1)]};
      case (bus.i_size)
         2'b00: begin
            load_val = {WORD_WIDTH{~bus.i_unsigned & byte_val[DATA_WIDTH-1]}};
            load_val[DATA_WIDTH-1:0] = byte_val;
         end
         2'b01: begin
            load_val = {WORD_WIDTH{~bus.i_unsigned & half_val[2*DATA_WIDTH-1]}};
            load_val[2*DATA_WIDTH-1:0] = half_val;
         end
         default: load_val = rd_word;
      endcase
   end

   // The sweep owns the array while clearing, so stores can only land in READY.
   always_ff @(posedge i_clk) begin
      if (state == CLEAR) begin
         mem[count] <= '0;
      end else if (store_go) begin
         for (int l = 0; l < LANES; l++) begin
            if (wr_mask[l]) begin
               mem[word_idx][l*DATA_WIDTH +: DATA_WIDTH] <= wr_data[l*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         bus.o_data   <= '0;
         bus.o_rvalid <= 1'b0;
         bus.o_err    <= 1'b0;
      end else begin
         bus.o_rvalid <= load_go;
         bus.o_err    <= err_go;
         if (err_go) begin
            bus.o_data <= '0;
         end else if (load_go) begin
            bus.o_data <= load_val;
         end
      end
   end
endmodule

// File: tb/tb_byte_lane_data_mem.sv
// Directed bench for byte_lane_data_mem: a byte-array model is compared every cycle,
// and literal expectations pin the key load results and sweep lengths.
module tb_byte_lane_data_mem;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic checkEn = 1'b0;
   int   checks = 0;
   int   failures = 0;

   byte_lane_data_mem_if bus ();

   byte_lane_data_mem dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Model: a flat byte array plus the number of sweep cycles still to run.
   logic [7:0]  mm [4096];
   int          clearLeft;
   logic        expRvalid, expErr;
   logic [31:0] expData;
   int          ma;
   int unsigned mv;
   bit          mLegal;
   wire         expReady = (clearLeft == 0);

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         clearLeft = 1024;
         expRvalid = 1'b0;
         expErr    = 1'b0;
         expData   = 32'h0;
      end else begin
         expRvalid = 1'b0;
         expErr    = 1'b0;
         if (clearLeft > 0) begin
            if (bus.i_clear) begin
               clearLeft = 1024;
            end else begin
               clearLeft = clearLeft - 1;
               if (clearLeft == 0) begin
                  for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
               end
            end
         end else if (bus.i_clear) begin
            clearLeft = 1024;
         end else if (bus.i_req) begin
            ma = int'(bus.i_addr);
            mLegal = (bus.i_size == 2'd0) || (bus.i_size == 2'd1 && ma % 2 == 0) ||
                     (bus.i_size == 2'd2 && ma % 4 == 0);
            if (!mLegal) begin
               expErr  = 1'b1;
               expData = 32'h0;
            end else if (bus.i_we) begin
               if (bus.i_size == 2'd0) begin
                  mm[ma] = bus.i_data[7:0];
               end else if (bus.i_size == 2'd1) begin
                  mm[ma]     = bus.i_data[15:8];
                  mm[ma + 1] = bus.i_data[7:0];
               end else begin
                  for (int k = 0; k < 4; k++) mm[ma + k] = 8'(bus.i_data >> (8 * (3 - k)));
               end
            end else begin
               if (bus.i_size == 2'd0) begin
                  mv = mm[ma];
                  if (!bus.i_unsigned && mv >= 128) mv = mv + 32'hFFFF_FF00;
               end else if (bus.i_size == 2'd1) begin
                  mv = mm[ma] * 256 + mm[ma + 1];
                  if (!bus.i_unsigned && mv >= 32768) mv = mv + 32'hFFFF_0000;
               end else begin
                  mv = ((mm[ma] * 256 + mm[ma + 1]) * 256 + mm[ma + 2]) * 256 + mm[ma + 3];
               end
               expData   = mv;
               expRvalid = 1'b1;
            end
         end
      end
   end

   task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checkEn) begin
         compareValue("model.ready",  32'(bus.o_ready),  32'(expReady));
         compareValue("model.rvalid", 32'(bus.o_rvalid), 32'(expRvalid));
         compareValue("model.err",    32'(bus.o_err),    32'(expErr));
         compareValue("model.data",   bus.o_data,        expData);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] data, input logic rvalid,
                              input logic err, input logic ready);
      compareValue({name, ".data"},   bus.o_data,         data);
      compareValue({name, ".rvalid"}, 32'(bus.o_rvalid),  32'(rvalid));
      compareValue({name, ".err"},    32'(bus.o_err),     32'(err));
      compareValue({name, ".ready"},  32'(bus.o_ready),   32'(ready));
   endtask

   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [11:0] addr, input logic [31:0] data);
      @(posedge clk);
      #1;
      bus.i_req      = 1'b1;
      bus.i_we       = we;
      bus.i_size     = size;
      bus.i_unsigned = uns;
      bus.i_addr     = addr;
      bus.i_data     = data;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      bus.i_req = 1'b0;
      bus.i_we  = 1'b0;
   endtask

   task automatic pulseClear();
      @(posedge clk);
      #1;
      bus.i_clear = 1'b1;
      @(posedge clk);
      #1;
      bus.i_clear = 1'b0;
   endtask

   task automatic waitReady(input string name);
      int n = 0;
      while (bus.o_ready !== 1'b1 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      compareValue(name, 32'(n), 32'd1024);
   endtask

   initial begin
      bus.i_clear = 1'b0; bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_size = 2'b00;
      bus.i_unsigned = 1'b0; bus.i_addr = '0; bus.i_data = '0;
      @(posedge clk);
      checkEn = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset", 32'h0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      waitReady("sweep_len");

      applyStimulus(0, 2'd2, 0, 12'h000, 0); idle();
      checkOutput("lw_000", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      applyStimulus(0, 2'd2, 0, 12'hFFC, 0); idle();
      checkOutput("lw_ffc", 32'h0000_0000, 1'b1, 1'b0, 1'b1);

      applyStimulus(1, 2'd2, 0, 12'h010, 32'h1122_3344);
      applyStimulus(0, 2'd2, 0, 12'h010, 0); idle();
      checkOutput("sw_lw_010", 32'h1122_3344, 1'b1, 1'b0, 1'b1);
      applyStimulus(0, 2'd0, 1, 12'h011, 0); idle();
      checkOutput("lbu_011", 32'h0000_0022, 1'b1, 1'b0, 1'b1);

      applyStimulus(1, 2'd0, 0, 12'h021, 32'h0000_00F0);
      applyStimulus(0, 2'd0, 0, 12'h021, 0); idle();
      checkOutput("lb_021", 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b1);
      applyStimulus(0, 2'd0, 1, 12'h021, 0); idle();
      checkOutput("lbu_021", 32'h0000_00F0, 1'b1, 1'b0, 1'b1);
      applyStimulus(0, 2'd2, 0, 12'h020, 0); idle();
      checkOutput("lw_020", 32'h00F0_0000, 1'b1, 1'b0, 1'b1);

      applyStimulus(1, 2'd1, 0, 12'h032, 32'h0000_ABCD);
      applyStimulus(0, 2'd1, 0, 12'h032, 0); idle();
      checkOutput("lh_032", 32'hFFFF_ABCD, 1'b1, 1'b0, 1'b1);
      applyStimulus(0, 2'd1, 1, 12'h032, 0); idle();
      checkOutput("lhu_032", 32'h0000_ABCD, 1'b1, 1'b0, 1'b1);
      applyStimulus(0, 2'd2, 0, 12'h030, 0); idle();
      checkOutput("lw_030", 32'h0000_ABCD, 1'b1, 1'b0, 1'b1);

      applyStimulus(0, 2'd1, 0, 12'h033, 0); idle();
      checkOutput("err_lh_033", 32'h0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1, 2'd2, 0, 12'h036, 32'h5566_7788); idle();
      checkOutput("err_sw_036", 32'h0, 1'b0, 1'b1, 1'b1);
      applyStimulus(0, 2'd3, 0, 12'h040, 0); idle();
      checkOutput("err_size11", 32'h0, 1'b0, 1'b1, 1'b1);
      idle();
      checkOutput("idle_no_pulse", 32'h0, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 2'd2, 0, 12'h034, 0); idle();
      checkOutput("lw_034", 32'h0000_0000, 1'b1, 1'b0, 1'b1);

      // A pending read pulse must vanish as soon as reset rises, without a clock edge.
      applyStimulus(0, 2'd2, 0, 12'h010, 0); idle();
      checkOutput("lw_before_reset", 32'h1122_3344, 1'b1, 1'b0, 1'b1);
      #1 reset = 1'b1;
      #1 checkOutput("reset_async", 32'h0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      waitReady("sweep_len_2");

      applyStimulus(1, 2'd2, 0, 12'h100, 32'hDEAD_BEEF);
      applyStimulus(0, 2'd2, 0, 12'h100, 0); idle();
      checkOutput("lw_100", 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
      pulseClear();
      applyStimulus(1, 2'd2, 0, 12'h200, 32'h1234_5678);
      applyStimulus(0, 2'd2, 0, 12'h100, 0); idle();
      checkOutput("sweep_ignored", 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      repeat (495) @(posedge clk);
      #3 reset = 1'b1;
      #1 checkOutput("reset_mid_sweep", 32'h0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      waitReady("sweep_len_3");
      applyStimulus(0, 2'd2, 0, 12'h100, 0); idle();
      checkOutput("lw_100_cleared", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      applyStimulus(0, 2'd2, 0, 12'h200, 0); idle();
      checkOutput("lw_200_cleared", 32'h0000_0000, 1'b1, 1'b0, 1'b1);

      @(posedge clk);
      @(negedge clk);
      checkEn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
